// File: rtl/usb_tx_gen_if.sv
// Bus between the USB transmitter and its surroundings: the request and FIFO
// side (driven by the endpoint logic) and the pad/status side (driven by the
// transmitter).
interface usb_tx_gen_if #(
    parameter int SIZE_W = 7
);
    logic [2:0]        tx_packet;
    logic [SIZE_W-1:0] tx_packet_size;
    logic [7:0]        tx_packet_data;
    logic              get_tx_packet_data;
    logic              dplus_out;
    logic              dminus_out;
    logic              tx_busy;
    logic              tx_done;

    // Endpoint side: issues requests and supplies payload bytes
    modport master (
        output tx_packet, tx_packet_size, tx_packet_data,
        input  get_tx_packet_data, dplus_out, dminus_out, tx_busy, tx_done
    );

    // Transmitter side
    modport slave (
        input  tx_packet, tx_packet_size, tx_packet_data,
        output get_tx_packet_data, dplus_out, dminus_out, tx_busy, tx_done
    );
endinterface

// File: rtl/usb_tx_gen.sv
// USB full-speed bulk-endpoint transmitter. Sends SYNC, PID, optional payload
// and CRC16, then EOP, NRZI-encoded with bit stuffing. The bit rate comes from
// a fractional phase accumulator (DIV_NUM/DIV_DEN clk cycles per bit).
module usb_tx_gen #(
    parameter int MAX_PKT_BYTES = 64,
    parameter int SIZE_W        = 7,
    parameter int DIV_NUM       = 25,
    parameter int DIV_DEN       = 3
) (
    input logic         clk,
    input logic         rst,
    usb_tx_gen_if.slave bus
);
    localparam int                ACC_W     = $clog2(DIV_NUM + DIV_DEN + 1);
    localparam logic [7:0]        SYNC_BYTE = 8'h80;
    localparam logic [SIZE_W-1:0] MAX_SIZE  = SIZE_W'(MAX_PKT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
    } state_t;

    // idx_q / state_q describe the bit currently on the line
    state_t            state_q;
    logic [3:0]        idx_q;
    logic [ACC_W-1:0]  acc_q;
    logic [2:0]        ones_q;
    logic [15:0]       crc_q;
    logic [7:0]        hold_q;
    logic [7:0]        pid_q;
    logic              is_data_q;
    logic [SIZE_W-1:0] left_q;     // payload bytes still to send, incl. current
    logic              line_q;     // NRZI level (1 = J)
    logic              dp_q, dm_q, get_q, busy_q, done_q, start_q;

    logic              req_valid_d, req_is_data_d;
    logic [7:0]        req_pid_d;
    logic [SIZE_W-1:0] size_clamp_d;
    logic [ACC_W-1:0]  acc_sum_d;
    logic              tick_d, advance_d, stuff_d;
    state_t            nstate_d;
    logic [3:0]        nidx_d;
    logic              bit_d, line_d, get_d, fb_d;
    logic [15:0]       crc_upd_d;

    // Decode the request code and clamp the requested payload size
    always_comb begin
        req_valid_d   = 1'b1;
        req_is_data_d = 1'b0;
        req_pid_d     = 8'h00;
        case (bus.tx_packet)
            3'd1:    begin req_pid_d = 8'hC3; req_is_data_d = 1'b1; end
            3'd2:    begin req_pid_d = 8'h4B; req_is_data_d = 1'b1; end
            3'd3:    req_pid_d = 8'hD2;
            3'd4:    req_pid_d = 8'h5A;
            3'd5:    req_pid_d = 8'h1E;
            default: req_valid_d = 1'b0;
        endcase
        size_clamp_d = (bus.tx_packet_size > MAX_SIZE) ? MAX_SIZE : bus.tx_packet_size;
    end

    // Bit strobe and stuffing decision; start_q launches the very first bit
    always_comb begin
        acc_sum_d = acc_q + ACC_W'(DIV_DEN);
        tick_d    = busy_q && (acc_sum_d >= ACC_W'(DIV_NUM));
        advance_d = start_q || tick_d;
        stuff_d   = advance_d && (ones_q == 3'd6) &&
                    (state_q == S_SYNC || state_q == S_PID ||
                     state_q == S_DATA || state_q == S_CRC);
    end

    // Next bit position, its logical value, FIFO pop request and CRC update
    always_comb begin
        nstate_d = state_q;
        nidx_d   = idx_q;
        if (!start_q) begin
            nidx_d = idx_q + 4'd1;
            case (state_q)
                S_SYNC: if (idx_q == 4'd7) begin nstate_d = S_PID; nidx_d = '0; end
                S_PID: if (idx_q == 4'd7) begin
                    nidx_d = '0;
                    if (left_q != '0)   nstate_d = S_DATA;
                    else if (is_data_q) nstate_d = S_CRC;
                    else                nstate_d = S_EOP_SE0;
                end
                S_DATA: if (idx_q == 4'd7) begin
                    nidx_d   = '0;
                    nstate_d = (left_q > SIZE_W'(1)) ? S_DATA : S_CRC;
                end
                S_CRC: if (idx_q == 4'd15) begin nstate_d = S_EOP_SE0; nidx_d = '0; end
                S_EOP_SE0: if (idx_q == 4'd1) begin nstate_d = S_EOP_J; nidx_d = '0; end
                default: begin nstate_d = S_IDLE; nidx_d = '0; end
            endcase
        end
        case (nstate_d)
            S_SYNC:  bit_d = SYNC_BYTE[nidx_d[2:0]];
            S_PID:   bit_d = pid_q[nidx_d[2:0]];
            S_DATA:  bit_d = hold_q[nidx_d[2:0]];
            S_CRC:   bit_d = ~crc_q[nidx_d];
            default: bit_d = 1'b1;
        endcase
        line_d    = bit_d ? line_q : ~line_q;
        // Pop the next byte during the last bit of the PID or of the current byte
        get_d     = (nstate_d == S_PID  && nidx_d == 4'd7 && left_q != '0) ||
                    (nstate_d == S_DATA && nidx_d == 4'd7 && left_q > SIZE_W'(1));
        fb_d      = crc_q[0] ^ bit_d;
        crc_upd_d = {1'b0, crc_q[15:1]} ^ (fb_d ? 16'hA001 : 16'h0000);
    end

    // Packet FSM with registered line, strobe and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;  idx_q <= '0;  acc_q <= '0;  ones_q <= '0;
            crc_q <= 16'hFFFF;  hold_q <= '0; pid_q <= '0;  is_data_q <= 1'b0;
            left_q <= '0;       line_q <= 1'b1;
            dp_q <= 1'b1;       dm_q <= 1'b0; get_q <= 1'b0;
            busy_q <= 1'b0;     done_q <= 1'b0; start_q <= 1'b0;
        end else begin
            get_q   <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            if (get_q) hold_q <= bus.tx_packet_data;
            if (state_q == S_IDLE) begin
                if (req_valid_d) begin
                    pid_q     <= req_pid_d;
                    is_data_q <= req_is_data_d;
                    left_q    <= req_is_data_d ? size_clamp_d : '0;
                    acc_q     <= '0;
                    idx_q     <= '0;
                    state_q   <= S_SYNC;
                    busy_q    <= 1'b1;
                    start_q   <= 1'b1;
                end
            end else begin
                acc_q <= tick_d ? (acc_sum_d - ACC_W'(DIV_NUM)) : acc_sum_d;
                if (stuff_d) begin
                    // Stuffed 0: toggle the line, hold position and CRC
                    line_q <= ~line_q;
                    dp_q   <= ~line_q;
                    dm_q   <= line_q;
                    ones_q <= '0;
                end else if (advance_d) begin
                    state_q <= nstate_d;
                    idx_q   <= nidx_d;
                    get_q   <= get_d;
                    if (!start_q && state_q == S_DATA && idx_q == 4'd7)
                        left_q <= left_q - SIZE_W'(1);
                    case (nstate_d)
                        S_SYNC, S_PID, S_DATA, S_CRC: begin
                            line_q <= line_d;
                            dp_q   <= line_d;
                            dm_q   <= ~line_d;
                            ones_q <= bit_d ? (ones_q + 3'd1) : 3'd0;
                            if (nstate_d == S_DATA) crc_q <= crc_upd_d;
                        end
                        S_EOP_SE0: begin
                            dp_q   <= 1'b0;
                            dm_q   <= 1'b0;
                            ones_q <= '0;
                        end
                        S_EOP_J: begin
                            line_q <= 1'b1;
                            dp_q   <= 1'b1;
                            dm_q   <= 1'b0;
                        end
                        default: begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            crc_q  <= 16'hFFFF;
                            ones_q <= '0;
                            acc_q  <= '0;
                            line_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.dplus_out          = dp_q;
    assign bus.dminus_out         = dm_q;
    assign bus.get_tx_packet_data = get_q;
    assign bus.tx_busy            = busy_q;
    assign bus.tx_done            = done_q;
endmodule
